// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the PHY TX link scheduler: default line symbols,
// lane count and the link-state encoding used by the activation FSM.
// -----------------------------------------------------------------------------
package phy_pkg;

  // Alignment/training symbol returned by the RX side.
  localparam logic [7:0] COM_SYM_DEFAULT  = 8'hBC;
  // Filler symbol driven on the TX byte stream when no lane data is sent.
  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'h7C;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    DOWN   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } link_state_t;

  // Encoding 3 is never produced; treat it as DOWN so a corrupted state
  // register recovers through the normal training path.
  function automatic link_state_t decode_state(input logic [1:0] raw);
    case (raw)
      2'd1:    return TRAIN;
      2'd2:    return ACTIVE;
      default: return DOWN;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin arbiter. The caller owns the
// pointer register; this block only picks the first requester at or after
// the pointer, wrapping 3 -> 0.
//
// Ports:
//   req [3:0] in   request per lane
//   ptr [1:0] in   lane with highest priority this cycle
//   gnt [3:0] out  one-hot grant (all zero when no request)
//   idx [1:0] out  index of the granted lane (equals ptr when no request)
// -----------------------------------------------------------------------------
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  // Requests rotated so that bit 0 is the lane pointed at; a fixed
  // priority pick on this vector is the round-robin pick on req.
  logic [3:0] rot_req;
  logic [1:0] off;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = req[ptr + 2'(gi)];
  end

  always_comb begin
    casez (rot_req)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    idx = ptr + off;
    gnt = (|req) ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/phy_tx_link_sched.sv
// -----------------------------------------------------------------------------
// phy_tx_link_sched
// TX-side link controller. A training FSM watches aligned RX bytes and
// declares the link active after LOCK_COUNT consecutive COM symbols; it drops
// the link after LOSS_COUNT cycles with no valid RX byte. While active, four
// single-entry lane buffers are drained round-robin onto one byte stream,
// one byte per grant, gated by tx_ready. Otherwise IDLE_SYM is sent and lane
// data stays buffered.
//
// Ports:
//   clk                  in   block clock
//   reset                in   asynchronous, active-low reset
//   rx_byte[7:0]         in   aligned byte from serial-to-parallel
//   rx_byte_valid        in   rx_byte meaningful this cycle
//   data_in0..3[7:0]     in   lane data
//   valid0..3            in   lane data valid
//   ready0..3            out  lane holding register empty (registered)
//   tx_ready             in   downstream accepts a byte this cycle
//   tx_data[7:0]         out  scheduled byte or IDLE_SYM
//   tx_valid             out  tx_data carries lane data
//   tx_lane[1:0]         out  source lane of tx_data (holds when idle)
//   active               out  link is up
//   link_state[1:0]      out  FSM state (DOWN=0, TRAIN=1, ACTIVE=2)
// -----------------------------------------------------------------------------
module phy_tx_link_sched
  import phy_pkg::*;
#(
  parameter logic [7:0]  COM_SYM    = COM_SYM_DEFAULT,
  parameter logic [7:0]  IDLE_SYM   = IDLE_SYM_DEFAULT,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [1:0] tx_lane,
  output logic       active,
  output logic [1:0] link_state
);

  logic [7:0]           lane_din [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld;

  logic [7:0]           hold_q [NUM_LANES];
  logic [7:0]           hold_d [NUM_LANES];
  logic [NUM_LANES-1:0] full_q, full_d;
  logic [1:0]           ptr_q, ptr_d;

  link_state_t          state_q, state_d;
  logic [3:0]           com_cnt_q, com_cnt_d;
  logic [7:0]           loss_cnt_q, loss_cnt_d;
  logic                 active_q, active_d;

  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [1:0]           tx_lane_q, tx_lane_d;

  logic                 grant;
  logic [3:0]           arb_gnt;
  logic [1:0]           arb_idx;

  assign lane_din[0] = data_in0;
  assign lane_din[1] = data_in1;
  assign lane_din[2] = data_in2;
  assign lane_din[3] = data_in3;
  assign lane_vld    = {valid3, valid2, valid1, valid0};

  // ---------------------------------------------------------------------------
  // Link activation FSM (next-state)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    com_cnt_d  = com_cnt_q;
    loss_cnt_d = loss_cnt_q;
    case (decode_state(state_q))
      DOWN: begin
        state_d    = DOWN;
        com_cnt_d  = '0;
        loss_cnt_d = '0;
        if (rx_byte_valid && (rx_byte == COM_SYM)) begin
          if (LOCK_COUNT == 1) begin
            state_d = ACTIVE;
          end else begin
            state_d   = TRAIN;
            com_cnt_d = 4'd1;
          end
        end
      end
      TRAIN: begin
        if (rx_byte_valid) begin
          if (rx_byte == COM_SYM) begin
            // This COM completes the run: go active on this edge.
            if (com_cnt_q == 4'(LOCK_COUNT - 1)) begin
              state_d   = ACTIVE;
              com_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end else begin
            state_d   = DOWN;
            com_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        // COM bytes are irrelevant here; only RX activity matters.
        if (rx_byte_valid) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q == 8'(LOSS_COUNT - 1)) begin
          state_d    = DOWN;
          loss_cnt_d = '0;
          com_cnt_d  = '0;
        end else begin
          loss_cnt_d = loss_cnt_q + 8'd1;
        end
      end
      default: state_d = DOWN;
    endcase
  end

  assign active_d = (state_d == ACTIVE);

  // ---------------------------------------------------------------------------
  // Scheduling: only while ACTIVE and not on the edge that leaves ACTIVE.
  // ---------------------------------------------------------------------------
  rr_arbiter4 u_arb (
    .req (full_q),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign grant = (state_q == ACTIVE) && (state_d == ACTIVE) && tx_ready && (|full_q);

  // Capture is gated by the registered empty flag only, so a lane being
  // drained this cycle cannot also accept; it reopens one cycle later.
  genvar gi;
  for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic take;
    logic load;
    assign take       = grant && arb_gnt[gi];
    assign load       = lane_vld[gi] && !full_q[gi];
    assign full_d[gi] = (full_q[gi] && !take) || load;
    assign hold_d[gi] = load ? lane_din[gi] : hold_q[gi];
  end

  always_comb begin
    tx_data_d  = IDLE_SYM;
    tx_valid_d = 1'b0;
    tx_lane_d  = tx_lane_q;
    ptr_d      = ptr_q;
    if (grant) begin
      tx_data_d  = hold_q[arb_idx];
      tx_valid_d = 1'b1;
      tx_lane_d  = arb_idx;
      ptr_d      = arb_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DOWN;
      com_cnt_q  <= '0;
      loss_cnt_q <= '0;
      active_q   <= 1'b0;
      full_q     <= '0;
      ptr_q      <= '0;
      tx_data_q  <= IDLE_SYM;
      tx_valid_q <= 1'b0;
      tx_lane_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      com_cnt_q  <= com_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      active_q   <= active_d;
      full_q     <= full_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_lane_q  <= tx_lane_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign ready0     = ~full_q[0];
  assign ready1     = ~full_q[1];
  assign ready2     = ~full_q[2];
  assign ready3     = ~full_q[3];
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_lane    = tx_lane_q;
  assign active     = active_q;
  assign link_state = state_q;

endmodule

// File: tb/tb_phy_tx_link_sched.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_link_sched
// Directed stimulus with literal expectations, plus a cycle-level reference
// model of the link rules compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_phy_tx_link_sched;

  localparam int LOCK = 4;
  localparam int LOSS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_byte_valid = 1'b0;
  logic [7:0] din [4];
  logic [3:0] vld = 4'h0;
  logic       tx_ready = 1'b0;

  logic       ready0, ready1, ready2, ready3;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [1:0] tx_lane;
  logic       active;
  logic [1:0] link_state;

  int tests = 0;
  int fails = 0;

  int         exp_ls  [4] = '{1, 1, 1, 2};
  int         exp_act [4] = '{0, 0, 0, 1};
  logic [7:0] rr_data [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  always #5 clk = ~clk;

  phy_tx_link_sched #(
    .COM_SYM    (8'hBC),
    .IDLE_SYM   (8'h7C),
    .LOCK_COUNT (LOCK),
    .LOSS_COUNT (LOSS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .data_in0      (din[0]),
    .data_in1      (din[1]),
    .data_in2      (din[2]),
    .data_in3      (din[3]),
    .valid0        (vld[0]),
    .valid1        (vld[1]),
    .valid2        (vld[2]),
    .valid3        (vld[3]),
    .ready0        (ready0),
    .ready1        (ready1),
    .ready2        (ready2),
    .ready3        (ready3),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_lane       (tx_lane),
    .active        (active),
    .link_state    (link_state)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: link state as a small integer, lane buffers as arrays.
  // ---------------------------------------------------------------------------
  int         m_state = 0;
  int         m_com   = 0;
  int         m_loss  = 0;
  int         m_ptr   = 0;
  logic [3:0] m_full  = 4'h0;
  logic [7:0] m_hold [4];
  logic [7:0] m_tx_data  = 8'h7C;
  logic       m_tx_valid = 1'b0;
  logic [1:0] m_tx_lane  = 2'd0;

  task automatic model_reset();
    m_state = 0; m_com = 0; m_loss = 0; m_ptr = 0; m_full = 4'h0;
    m_tx_data = 8'h7C; m_tx_valid = 1'b0; m_tx_lane = 2'd0;
    for (int i = 0; i < 4; i++) m_hold[i] = 8'h00;
  endtask

  task automatic model_step();
    int ns;
    int g;
    int l;
    logic [3:0] before_full;
    before_full = m_full;
    ns = m_state;
    if (m_state == 0) begin
      if (rx_byte_valid && rx_byte == 8'hBC) begin
        m_com = 1;
        ns = (LOCK == 1) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      if (rx_byte_valid) begin
        if (rx_byte == 8'hBC) begin
          m_com = m_com + 1;
          if (m_com >= LOCK) ns = 2;
        end else begin
          m_com = 0;
          ns = 0;
        end
      end
    end else begin
      m_loss = rx_byte_valid ? 0 : m_loss + 1;
      if (m_loss >= LOSS) begin
        ns = 0; m_loss = 0; m_com = 0;
      end
    end
    g = -1;
    if (m_state == 2 && ns == 2 && tx_ready) begin
      for (int k = 0; k < 4; k++) begin
        l = (m_ptr + k) % 4;
        if (g < 0 && m_full[l]) g = l;
      end
    end
    if (g >= 0) begin
      m_tx_data  = m_hold[g];
      m_tx_valid = 1'b1;
      m_tx_lane  = 2'(g);
      m_ptr      = (g + 1) % 4;
      m_full[g]  = 1'b0;
    end else begin
      m_tx_data  = 8'h7C;
      m_tx_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && !before_full[i]) begin
        m_full[i] = 1'b1;
        m_hold[i] = din[i];
      end
    end
    m_state = ns;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  logic [3:0] rdy_got, rdy_exp;
  always @(negedge clk) begin
    rdy_got = {ready3, ready2, ready1, ready0};
    rdy_exp = ~m_full;
    chk("model tx_data",    tx_data,    m_tx_data);
    chk("model tx_valid",   tx_valid,   m_tx_valid);
    chk("model tx_lane",    tx_lane,    m_tx_lane);
    chk("model active",     active,     m_state == 2);
    chk("model link_state", link_state, m_state);
    chk("model ready",      rdy_got,    rdy_exp);
    if (reset && tx_valid)
      $display("[TB] t=%0t tx lane %0d data %02h", $time, tx_lane, tx_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    #1 reset = 1'b0;
    #2;
    chk("reset active",     active,     0);
    chk("reset link_state", link_state, 0);
    chk("reset tx_data",    tx_data,    8'h7C);
    chk("reset tx_valid",   tx_valid,   0);
    chk("reset ready",      {ready3, ready2, ready1, ready0}, 4'hF);
    #9 reset = 1'b1;
    cyc();

    // Training aborted by a non-COM byte after two COMs
    rx_byte_valid = 1'b1; rx_byte = 8'hBC;
    cyc(); chk("abort train1", link_state, 1);
    cyc(); chk("abort train2", link_state, 1);
    rx_byte = 8'h3C;
    cyc(); chk("abort to down", link_state, 0);

    // Full training run
    rx_byte = 8'hBC;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("train link_state", link_state, exp_ls[i]);
      chk("train active",     active,     exp_act[i]);
    end

    // Round-robin order, all four lanes loaded at once
    tx_ready = 1'b1;
    din[0] = 8'h10; din[1] = 8'h21; din[2] = 8'h32; din[3] = 8'h43;
    vld = 4'hF;
    cyc();
    chk("rr capture tx_valid", tx_valid, 0);
    chk("rr capture ready", {ready3, ready2, ready1, ready0}, 4'h0);
    vld = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr tx_data",  tx_data,  rr_data[i]);
      chk("rr tx_lane",  tx_lane,  i);
      chk("rr tx_valid", tx_valid, 1);
    end
    cyc();
    chk("rr idle tx_data",  tx_data,  8'h7C);
    chk("rr idle tx_valid", tx_valid, 0);
    chk("rr idle tx_lane",  tx_lane,  3);

    // Pointer wrap: drive pointer to 3, then lanes 1 and 3 pending
    din[2] = 8'h52; vld = 4'b0100;
    cyc(); vld = 4'h0;
    cyc(); chk("wrap setup tx_data", tx_data, 8'h52);
    tx_ready = 1'b0;
    din[1] = 8'h61; din[3] = 8'h73; vld = 4'b1010;
    cyc(); chk("wrap hold tx_valid", tx_valid, 0);
    vld = 4'h0; tx_ready = 1'b1;
    cyc(); chk("wrap first lane", tx_lane, 3); chk("wrap first data", tx_data, 8'h73);
    cyc(); chk("wrap second lane", tx_lane, 1); chk("wrap second data", tx_data, 8'h61);
    // Pointer should now be 2: lane 2 must win over lane 0
    tx_ready = 1'b0;
    din[0] = 8'h80; din[2] = 8'h82; vld = 4'b0101;
    cyc(); vld = 4'h0; tx_ready = 1'b1;
    cyc(); chk("ptr end lane", tx_lane, 2); chk("ptr end data", tx_data, 8'h82);
    cyc(); chk("ptr next lane", tx_lane, 0); chk("ptr next data", tx_data, 8'h80);

    // Backpressure
    tx_ready = 1'b0;
    din[2] = 8'hA5; vld = 4'b0100;
    cyc(); vld = 4'h0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp tx_valid", tx_valid, 0);
      chk("bp ready2",   ready2,   0);
    end
    tx_ready = 1'b1;
    cyc();
    chk("bp release data", tx_data, 8'hA5);
    chk("bp release lane", tx_lane, 2);
    chk("bp release valid", tx_valid, 1);

    // Link loss with data held, then retrain and drain
    tx_ready = 1'b0;
    din[2] = 8'hA5; vld = 4'b0100;
    cyc(); vld = 4'h0;
    rx_byte_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("loss active", active, (i < 8) ? 1 : 0);
    end
    chk("loss link_state", link_state, 0);
    chk("loss ready2 held", ready2, 0);
    rx_byte_valid = 1'b1; rx_byte = 8'hBC;
    for (int i = 0; i < 4; i++) cyc();
    chk("retrain active", active, 1);
    tx_ready = 1'b1;
    cyc();
    chk("retrain data", tx_data, 8'hA5);
    chk("retrain lane", tx_lane, 2);

    // Grant while the source is offering the next byte on the same lane
    tx_ready = 1'b0;
    din[1] = 8'h11; vld = 4'b0010;
    cyc();
    din[1] = 8'h22;
    tx_ready = 1'b1;
    cyc();
    chk("same-lane first data", tx_data, 8'h11);
    chk("same-lane ready1 reopen", ready1, 1);
    cyc();
    chk("same-lane gap valid", tx_valid, 0);
    chk("same-lane ready1 refill", ready1, 0);
    vld = 4'h0;
    cyc();
    chk("same-lane second data", tx_data, 8'h22);
    chk("same-lane second lane", tx_lane, 1);

    // Asynchronous reset between edges with every lane full
    tx_ready = 1'b0;
    din[0] = 8'h01; din[1] = 8'h02; din[2] = 8'h03; din[3] = 8'h04;
    vld = 4'hF;
    cyc(); vld = 4'h0;
    cyc();
    chk("pre-reset ready", {ready3, ready2, ready1, ready0}, 4'h0);
    chk("pre-reset active", active, 1);
    #2 reset = 1'b0;
    #1;
    chk("async active",     active,     0);
    chk("async tx_data",    tx_data,    8'h7C);
    chk("async tx_valid",   tx_valid,   0);
    chk("async tx_lane",    tx_lane,    0);
    chk("async link_state", link_state, 0);
    chk("async ready",      {ready3, ready2, ready1, ready0}, 4'hF);
    #20 reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
